// File: rtl/axi_lite_regfile_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_regfile_slave_if : AXI4-Lite bus bundle (no response codes) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface axi_lite_regfile_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
  );

  // Same direction set as slave; the register file binds to this name.
  modport DUT (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_regfile_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_regfile_slave : AXI4-Lite slave backed by a 32-bit regfile  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_lite_regfile_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic              ACLK,
  input  wire logic              ARESET,
  axi_lite_regfile_slave_if.DUT  s_axi
);
  localparam int c_SEL_W    = ADDR_WIDTH - 2;
  localparam int c_NUM_REGS = 1 << c_SEL_W;
  localparam int c_STRB_W   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_HAVE_ADDR = 2'd1,
    WR_HAVE_DATA = 2'd2,
    WR_RESP      = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  wr_state_t              r_wr_state;
  rd_state_t              r_rd_state;
  logic                   r_awready;
  logic                   r_wready;
  logic                   r_bvalid;
  logic                   r_arready;
  logic                   r_rvalid;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [c_SEL_W-1:0]     r_awsel;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [c_STRB_W-1:0]    r_wstrb;
  logic [DATA_WIDTH-1:0]  r_regs [c_NUM_REGS];

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_commit;
  logic [c_SEL_W-1:0]     w_sel;
  logic [DATA_WIDTH-1:0]  w_cdata;
  logic [c_STRB_W-1:0]    w_cstrb;
  logic                   w_unused_addr_lsbs;

  assign w_aw_hs = r_awready & s_axi.AWVALID;
  assign w_w_hs  = r_wready  & s_axi.WVALID;

  // Byte-lane bits never reach the register select.
  assign w_unused_addr_lsbs = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  // Commit source: live bus fields unless one half was latched earlier.
  always_comb begin
    w_commit = 1'b0;
    w_sel    = s_axi.AWADDR[ADDR_WIDTH-1:2];
    w_cdata  = s_axi.WDATA;
    w_cstrb  = s_axi.WSTRB;
    case (r_wr_state)
      WR_IDLE:      w_commit = w_aw_hs & w_w_hs;
      WR_HAVE_ADDR: begin
        w_commit = w_w_hs;
        w_sel    = r_awsel;
      end
      WR_HAVE_DATA: begin
        w_commit = w_aw_hs;
        w_cdata  = r_wdata;
        w_cstrb  = r_wstrb;
      end
      default:      w_commit = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_awsel    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (w_commit) begin
            r_wr_state <= WR_RESP;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b1;
          end else if (w_aw_hs) begin
            r_wr_state <= WR_HAVE_ADDR;
            r_awsel    <= s_axi.AWADDR[ADDR_WIDTH-1:2];
            r_awready  <= 1'b0;
          end else if (w_w_hs) begin
            r_wr_state <= WR_HAVE_DATA;
            r_wdata    <= s_axi.WDATA;
            r_wstrb    <= s_axi.WSTRB;
            r_wready   <= 1'b0;
          end
        end
        WR_HAVE_ADDR, WR_HAVE_DATA: begin
          if (w_commit) begin
            r_wr_state <= WR_RESP;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b1;
          end
        end
        WR_RESP: begin
          if (s_axi.BREADY) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_bvalid   <= 1'b0;
          end
        end
        default: begin
          r_wr_state <= WR_IDLE;
          r_awready  <= 1'b1;
          r_wready   <= 1'b1;
          r_bvalid   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      for (int b = 0; b < c_STRB_W; b++) begin
        if (w_cstrb[b]) begin
          r_regs[w_sel][8*b +: 8] <= w_cdata[8*b +: 8];
        end
      end
    end
  end

  // Reads sample the array before any same-edge commit lands: old data wins.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (s_axi.ARVALID) begin
            r_rd_state <= RD_RESP;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= r_regs[s_axi.ARADDR[ADDR_WIDTH-1:2]];
          end
        end
        RD_RESP: begin
          if (s_axi.RREADY) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
          end
        end
        default: begin
          r_rd_state <= RD_IDLE;
          r_arready  <= 1'b1;
          r_rvalid   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.ARREADY = r_arready;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RDATA   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_lite_regfile_slave : scoreboard bench for the AXI-Lite regfile|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axi_lite_regfile_slave;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] mdl [4];
  logic [31:0] exp_q [$];

  axi_lite_regfile_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axi_lite_regfile_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s_axi  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output bit ok);
    int  t;
    bit  aw_hs, w_hs;
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    t = 0;
    while ((bus.AWVALID || bus.WVALID) && t < 20) begin
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      step();
      if (aw_hs) bus.AWVALID = 1'b0;
      if (w_hs)  bus.WVALID  = 1'b0;
      t++;
    end
    ok = !(bus.AWVALID || bus.WVALID);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    t = 0;
    while (!bus.BVALID && t < 20) begin step(); t++; end
    if (!bus.BVALID) ok = 1'b0;
    step();
    bus.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output bit ok);
    int t;
    ok = 1'b1;
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    t = 0;
    while (!bus.ARREADY && t < 20) begin step(); t++; end
    if (!bus.ARREADY) ok = 1'b0;
    step();
    bus.ARVALID = 1'b0;
    t = 0;
    while (!bus.RVALID && t < 20) begin step(); t++; end
    if (!bus.RVALID) ok = 1'b0;
    d = bus.RDATA;
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex;
    bit ok;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    n_cmp++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b11100) begin
      n_err++;
      $display("FAIL reset_ctrl: got aw/w/ar/b/r=%b want 11100",
               {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
    end
    n_cmp++;
    if (bus.RDATA !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 00000000", bus.RDATA);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mdl[i]);
      do_read(4'(i * 4), rd, ok);
      ex = exp_q.pop_front();
      n_cmp++;
      if (!ok || rd !== ex) begin
        n_err++; $display("FAIL reset_read[%0d]: got %h ok=%0d want %h", i, rd, ok, ex);
      end
    end
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd, ex;
    bit ok;
    bus.AWADDR = 4'h4; bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    mdl[1] = merge(mdl[1], 32'hDEADBEEF, 4'hF);
    n_cmp++;
    if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b100) begin
      n_err++; $display("FAIL full_bvalid: got b/aw/w=%b want 100",
                        {bus.BVALID, bus.AWREADY, bus.WREADY});
    end
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    n_cmp++;
    if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011) begin
      n_err++; $display("FAIL full_bdone: got b/aw/w=%b want 011",
                        {bus.BVALID, bus.AWREADY, bus.WREADY});
    end
    exp_q.push_back(mdl[1]);
    do_read(4'h4, rd, ok);
    ex = exp_q.pop_front();
    n_cmp++;
    if (!ok || rd !== ex) begin
      n_err++; $display("FAIL full_read: got %h ok=%0d want %h", rd, ok, ex);
    end
  endtask

  task automatic test_out_of_order();
    logic [31:0] rd, ex;
    bit ok;
    do_write(4'h8, 32'hAABBCCDD, 4'hF, ok);
    mdl[2] = merge(mdl[2], 32'hAABBCCDD, 4'hF);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL ooo_prewrite: got timeout want done"); end
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'h5; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b100) begin
        n_err++; $display("FAIL ooo_wait[%0d]: got aw/w/b=%b want 100", c,
                          {bus.AWREADY, bus.WREADY, bus.BVALID});
      end
      step();
    end
    bus.AWADDR = 4'h9; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    mdl[2] = merge(mdl[2], 32'h11223344, 4'h5);
    n_cmp++;
    if (bus.BVALID !== 1'b1) begin
      n_err++; $display("FAIL ooo_bvalid: got %b want 1", bus.BVALID);
    end
    bus.BREADY = 1'b1; step(); bus.BREADY = 1'b0;
    exp_q.push_back(mdl[2]);
    do_read(4'h8, rd, ok);
    ex = exp_q.pop_front();
    n_cmp++;
    if (!ok || rd !== ex || ex !== 32'hAA22CC44) begin
      n_err++; $display("FAIL ooo_read: got %h ok=%0d want %h", rd, ok, ex);
    end
  endtask

  task automatic test_backpressure();
    bus.AWADDR = 4'h0; bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF;
    bus.ARADDR = 4'h4;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    exp_q.push_back(mdl[1]);
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    mdl[0] = merge(mdl[0], 32'h0BADF00D, 4'hF);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY} !== 5'b11000
          || bus.RDATA !== exp_q[0]) begin
        n_err++; $display("FAIL bp_hold[%0d]: got b/r/aw/w/ar=%b rdata=%h want 11000 %h", c,
                          {bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY},
                          bus.RDATA, exp_q[0]);
      end
      step();
    end
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    step();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    void'(exp_q.pop_front());
    n_cmp++;
    if ({bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY} !== 5'b00111) begin
      n_err++; $display("FAIL bp_release: got b/r/aw/w/ar=%b want 00111",
                        {bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd, ex;
    bit ok;
    bus.AWADDR = 4'hC; bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF;
    bus.ARADDR = 4'hC;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    exp_q.push_back(mdl[3]);
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    mdl[3] = merge(mdl[3], 32'hCAFEF00D, 4'hF);
    ex = exp_q.pop_front();
    n_cmp++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== ex) begin
      n_err++; $display("FAIL coll_old: got rvalid=%b rdata=%h want 1 %h", bus.RVALID, bus.RDATA, ex);
    end
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    step();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    exp_q.push_back(mdl[3]);
    do_read(4'hC, rd, ok);
    ex = exp_q.pop_front();
    n_cmp++;
    if (!ok || rd !== ex) begin
      n_err++; $display("FAIL coll_new: got %h ok=%0d want %h", rd, ok, ex);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ex;
    bit ok;
    bus.AWADDR = 4'h0; bus.AWVALID = 1'b1;
    bus.ARADDR = 4'h4; bus.ARVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    n_cmp++;
    if ({bus.AWREADY, bus.WREADY, bus.RVALID} !== 3'b011 || bus.RDATA !== mdl[1]) begin
      n_err++; $display("FAIL mid_haveaddr: got aw/w/r=%b rdata=%h want 011 %h",
                        {bus.AWREADY, bus.WREADY, bus.RVALID}, bus.RDATA, mdl[1]);
    end
    bus.WDATA = 32'h55555555; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0; bus.WVALID = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    n_cmp++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b11100
        || bus.RDATA !== 32'h0) begin
      n_err++; $display("FAIL mid_rst1: got aw/w/ar/b/r=%b rdata=%h want 11100 00000000",
                        {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, bus.RDATA);
    end
    bus.AWADDR = 4'h4; bus.WDATA = 32'h12345678; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    n_cmp++;
    if (bus.BVALID !== 1'b1) begin
      n_err++; $display("FAIL mid_bpending: got %b want 1", bus.BVALID);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b11100) begin
      n_err++; $display("FAIL mid_rst2: got aw/w/ar/b/r=%b want 11100",
                        {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mdl[i]);
      do_read(4'(i * 4), rd, ok);
      ex = exp_q.pop_front();
      n_cmp++;
      if (!ok || rd !== ex) begin
        n_err++; $display("FAIL mid_read[%0d]: got %h ok=%0d want %h", i, rd, ok, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ex, d;
    logic [3:0]  a, s;
    bit ok;
    for (int n = 0; n < 10; n++) begin
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      s = (n == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      do_write(a, d, s, ok);
      mdl[a[3:2]] = merge(mdl[a[3:2]], d, s);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b_write[%0d]: got timeout want done", n); end
      a = 4'($urandom_range(0, 15));
      exp_q.push_back(mdl[a[3:2]]);
      do_read(a, rd, ok);
      ex = exp_q.pop_front();
      n_cmp++;
      if (!ok || rd !== ex) begin
        n_err++; $display("FAIL b2b_read[%0d]: addr=%h got %h ok=%0d want %h", n, a, rd, ok, ex);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    test_reset();
    test_full_write_read();
    test_out_of_order();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
